lsu_load_unit: RTL and testbench

- Load-side counterpart to the register-file store path: accepts a load from the execute stage and computes address = base + sign-extended imm.
- Issues a single aligned 64-bit read to data memory over a valid/ready request and valid response interface.
- Extracts byte/half/word/dword, sign- or zero-extends it, and drives one register-file write-back pulse.
- Sits between the EXU and the register file write port.

---
 rtl/lsu_load_unit_if.sv | 35 +++
 rtl/lsu_load_unit.sv | 160 ++++++++++++++++
 tb/tb_lsu_load_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_load_unit_if.sv
// ---------------------------------------------------------------------------
// lsu_load_unit_if
// Data-memory read channel between the load unit and data memory.
//   mem_req_valid / mem_req_ready : request handshake (unit -> memory)
//   mem_req_addr                  : 8-byte aligned read address
//   mem_rsp_valid                 : read data valid (no back-pressure)
//   mem_rsp_data                  : aligned doubleword returned by memory
// Modports: master = load unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface lsu_load_unit_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/lsu_load_unit.sv
// ---------------------------------------------------------------------------
// lsu_load_unit
// Load unit between the EXU and the register-file write port. Accepts one
// load at a time, computes ea = base + sext(imm), issues one aligned 64-bit
// read, extracts byte/half/word/dword at ea[2:0], sign/zero-extends it and
// drives a single write-back pulse.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   ld_valid/ld_ready : load request handshake (ready only when idle)
//   ld_base, ld_imm   : base register value, 32-bit signed offset
//   ld_size           : 0=byte 1=half 2=word 3=dword
//   ld_unsigned       : 1=zero-extend, 0=sign-extend
//   ld_rd             : destination register
//   mem               : data-memory read channel (lsu_load_unit_if.master)
//   wb_wen/waddr/wdata: register write-back (wen is a one-cycle pulse)
//   ld_fault          : misaligned-load pulse
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned loads
// (no memory access, one-cycle ld_fault). Without it ld_fault is tied 0 and
// misaligned loads read the aligned doubleword with zero fill at the top.
// ---------------------------------------------------------------------------
module lsu_load_unit #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_W-1:0]     ld_base,
    input  logic [31:0]           ld_imm,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    lsu_load_unit_if.master       mem,
    output logic                  wb_wen,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic                  ld_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       ea_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [REG_ADDR_W-1:0]   rd_q;

    logic signed [ADDR_W-1:0] imm_sext;
    logic [ADDR_W-1:0]        ea_d;
    logic                     accept;
    logic                     trap_d;
    logic                     fault_q;

    // Shift the doubleword down by the byte offset (zero fill at the top),
    // keep the low 8/16/32/64 bits and extend to DATA_W.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] dw,
        input logic [2:0]        off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        sh = dw >> {off, 3'b000};
        case (size)
            2'd0:    r = uns ? DATA_W'(sh[7:0])  : {{(DATA_W-8){sh[7]}},   sh[7:0]};
            2'd1:    r = uns ? DATA_W'(sh[15:0]) : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            2'd2:    r = uns ? DATA_W'(sh[31:0]) : {{(DATA_W-32){sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    assign imm_sext = {{(ADDR_W-32){ld_imm[31]}}, ld_imm};
    assign ea_d     = ld_base + $unsigned(imm_sext);
    assign accept   = ld_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        trap_d = 1'b0;
        case (ld_size)
            2'd1:    trap_d = ea_d[0];
            2'd2:    trap_d = (ea_d[1:0] != 2'b00);
            2'd3:    trap_d = (ea_d[2:0] != 3'b000);
            default: trap_d = 1'b0;
        endcase
    end

    // Marks a WB visit caused by a trap rather than a completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (accept) begin
            fault_q <= trap_d;
        end
    end

    assign ld_fault = (state_q == WB) && fault_q;
`else
    assign trap_d   = 1'b0;
    assign fault_q  = 1'b0;
    assign ld_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ld_valid) state_d = trap_d ? WB : REQ;
            REQ:     if (mem.mem_req_ready) state_d = WAIT;
            WAIT:    if (mem.mem_rsp_valid) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accept: latch the load fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea_q   <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
            rd_q   <= '0;
        end else if (accept) begin
            ea_q   <= ea_d;
            size_q <= ld_size;
            uns_q  <= ld_unsigned;
            rd_q   <= ld_rd;
        end
    end

    // Response: register the extracted result; held until the next response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wdata <= '0;
            wb_waddr <= '0;
        end else if ((state_q == WAIT) && mem.mem_rsp_valid) begin
            wb_wdata <= load_extend(mem.mem_rsp_data, ea_q[2:0], size_q, uns_q);
            wb_waddr <= rd_q;
        end
    end

    assign ld_ready          = (state_q == IDLE);
    assign mem.mem_req_valid = (state_q == REQ);
    assign mem.mem_req_addr  = {ea_q[ADDR_W-1:3], 3'b000};
    // x0 is never written, but the memory transaction still takes place.
    assign wb_wen            = (state_q == WB) && !fault_q && (rd_q != '0);

endmodule

// File: tb/tb_lsu_load_unit.sv
// ---------------------------------------------------------------------------
// tb_lsu_load_unit
// Directed bench for lsu_load_unit with a byte-level reference model, an
// expected write-back queue and a per-cycle compare process.
// ---------------------------------------------------------------------------
module tb_lsu_load_unit;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  ld_valid = 1'b0;
    logic                  ld_ready;
    logic [ADDR_W-1:0]     ld_base = '0;
    logic [31:0]           ld_imm = '0;
    logic [1:0]            ld_size = '0;
    logic                  ld_unsigned = 1'b0;
    logic [REG_ADDR_W-1:0] ld_rd = '0;
    logic                  wb_wen;
    logic [REG_ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0]     wb_wdata;
    logic                  ld_fault;

    lsu_load_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    lsu_load_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_base     (ld_base),
        .ld_imm      (ld_imm),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ld_rd       (ld_rd),
        .mem         (mem_if),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .ld_fault    (ld_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    wb_t         exp_q[$];
    logic [63:0] exp_addr = '0;
    logic [63:0] last_wdata = '0;
    bit          chk_en = 1'b0;
    int          wb_seen = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
        end
    endtask

    // Reference: pick the bytes at ea+i out of the doubleword one at a time;
    // bytes past the end of the doubleword read as zero.
    function automatic logic [63:0] model_load(input logic [63:0] base, input logic [31:0] imm,
                                               input logic [1:0] size, input bit uns,
                                               input logic [63:0] data);
        logic [63:0] ea;
        logic [63:0] v;
        logic [7:0]  b [8];
        int          off;
        int          n;
        ea  = base + {{32{imm[31]}}, imm};
        off = int'(ea[2:0]);
        n   = 1 << size;
        for (int j = 0; j < 8; j++) b[j] = data[8*j +: 8];
        v = '0;
        for (int i = 0; i < n; i++) if (off + i < 8) v[8*i +: 8] = b[off+i];
        if (!uns && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [63:0] ea, input logic [1:0] size);
        int n;
        n = 1 << size;
        return (ea % n) != 0;
    endfunction

    // Per-cycle compare against the expected address and write-back queue.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (mem_if.mem_req_valid) check("req_addr", mem_if.mem_req_addr, exp_addr);
            if (wb_wen) begin
                wb_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", 64'd1, 64'd0);
                end else begin
                    check("wb_waddr", 64'(wb_waddr), 64'(exp_q[0].rd));
                    check("wb_wdata", wb_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
`ifndef LSU_MISALIGN_TRAP_EN
            if (ld_fault) check("ld_fault_tied0", 64'(ld_fault), 64'd0);
`endif
        end
    end

    task automatic wait_idle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!ld_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ld_ready_before_accept", 64'(ld_ready), 64'd1);
    endtask

    task automatic do_load(input logic [63:0] base, input logic [31:0] imm, input logic [1:0] size,
                           input bit uns, input logic [4:0] rd, input logic [63:0] data,
                           input int stall);
        logic [63:0] ea;
        logic [63:0] res;
        bit          trap;
        ea  = base + {{32{imm[31]}}, imm};
        res = model_load(base, imm, size, uns, data);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = model_misaligned(ea, size);
`else
        trap = 1'b0;
`endif
        wait_idle();
        exp_addr = {ea[63:3], 3'b000};
        if (!trap && rd != 0) exp_q.push_back('{rd, res});
        ld_base = base; ld_imm = imm; ld_size = size; ld_unsigned = uns; ld_rd = rd;
        ld_valid = 1'b1;
        @(posedge clk);
        #1 ld_valid = 1'b0;
        if (trap) begin
            @(negedge clk);
            check("trap_fault", 64'(ld_fault), 64'd1);
            check("trap_no_req", 64'(mem_if.mem_req_valid), 64'd0);
            check("trap_no_wen", 64'(wb_wen), 64'd0);
            check("trap_wdata_kept", wb_wdata, last_wdata);
            @(negedge clk);
            check("trap_fault_pulse", 64'(ld_fault), 64'd0);
            check("trap_ready_back", 64'(ld_ready), 64'd1);
        end else begin
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check("stall_req_valid", 64'(mem_if.mem_req_valid), 64'd1);
                check("stall_ld_ready", 64'(ld_ready), 64'd0);
            end
            @(negedge clk);
            check("req_valid", 64'(mem_if.mem_req_valid), 64'd1);
            mem_if.mem_req_ready = 1'b1;
            @(posedge clk);
            #1 mem_if.mem_req_ready = 1'b0;
            @(negedge clk);
            check("wait_no_req", 64'(mem_if.mem_req_valid), 64'd0);
            check("wait_no_wen", 64'(wb_wen), 64'd0);
            mem_if.mem_rsp_valid = 1'b1;
            mem_if.mem_rsp_data  = data;
            @(posedge clk);
            #1 mem_if.mem_rsp_valid = 1'b0;
            mem_if.mem_rsp_data = 64'hA5A5_A5A5_A5A5_A5A5;
            @(negedge clk);
            check("wb_wen_timing", 64'(wb_wen), 64'(rd != 0));
            check("wb_ld_ready", 64'(ld_ready), 64'd0);
            check("wb_no_fault", 64'(ld_fault), 64'd0);
            last_wdata = res;
            @(negedge clk);
            check("wen_pulse", 64'(wb_wen), 64'd0);
            check("ready_after_wb", 64'(ld_ready), 64'd1);
            check("wdata_hold", wb_wdata, res);
        end
    endtask

    initial begin
        int wb_before;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_data  = '0;

        // Pin the model against hand-computed values
        check("model_t1", model_load(64'h8000_0000, 32'd4, 2'd2, 1'b0, 64'h8765_4321_0000_0000),
              64'hFFFF_FFFF_8765_4321);
        check("model_t2u", model_load(64'h8000_0000, 32'd4, 2'd2, 1'b1, 64'h8765_4321_0000_0000),
              64'h0000_0000_8765_4321);
        check("model_t2b", model_load(64'h8000_0000, 32'd7, 2'd0, 1'b0, 64'h8011_2233_4455_6677),
              64'hFFFF_FFFF_FFFF_FF80);
        check("model_t6", model_load(64'h1001, 32'd0, 2'd1, 1'b0, 64'h0000_0000_00C3_B200),
              64'hFFFF_FFFF_FFFF_C3B2);
        check("model_wrap", model_load(64'h1006, 32'd0, 2'd2, 1'b0, 64'h8899_0000_0000_0000),
              64'h0000_0000_0000_8899);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("rst_req_addr", mem_if.mem_req_addr, 64'd0);
        check("rst_wb_wen", 64'(wb_wen), 64'd0);
        check("rst_wb_waddr", 64'(wb_waddr), 64'd0);
        check("rst_wb_wdata", wb_wdata, 64'd0);
        check("rst_ld_fault", 64'(ld_fault), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Stale response while idle is ignored
        @(negedge clk);
        mem_if.mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_if.mem_rsp_valid = 1'b0;
        check("idle_rsp_ignored", 64'(ld_ready), 64'd1);

        // 1: signed word, minimum latency
        do_load(64'h8000_0000, 32'd4, 2'd2, 1'b0, 5'd5, 64'h8765_4321_0000_0000, 0);
        check("t1_wdata_lit", wb_wdata, 64'hFFFF_FFFF_8765_4321);
        check("t1_waddr_lit", 64'(wb_waddr), 64'd5);
        // 2: unsigned word, signed byte at offset 7
        do_load(64'h8000_0000, 32'd4, 2'd2, 1'b1, 5'd5, 64'h8765_4321_0000_0000, 0);
        check("t2u_wdata_lit", wb_wdata, 64'h0000_0000_8765_4321);
        do_load(64'h8000_0000, 32'd7, 2'd0, 1'b0, 5'd6, 64'h8011_2233_4455_6677, 0);
        check("t2b_wdata_lit", wb_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        // Negative offset, unsigned half; dword with unsigned set
        do_load(64'h2000, 32'hFFFF_FFF8, 2'd1, 1'b1, 5'd7, 64'h1122_3344_5566_7788, 0);
        do_load(64'h100, 32'h10, 2'd3, 1'b1, 5'd9, 64'hDEAD_BEEF_CAFE_F00D, 0);
        // 3: four stall cycles on the request
        wb_before = wb_seen;
        do_load(64'h4000, 32'h22, 2'd1, 1'b0, 5'd10, 64'h0000_0000_F00D_0000, 4);
        check("t3_single_wb", 64'(wb_seen - wb_before), 64'd1);
        // 4: rd=0 dword
        wb_before = wb_seen;
        do_load(64'h5000, 32'h8, 2'd3, 1'b0, 5'd0, 64'h0123_4567_89AB_CDEF, 1);
        check("t4_no_wb", 64'(wb_seen - wb_before), 64'd0);

        // 5: reset while waiting for the response
        wait_idle();
        exp_addr = 64'h3008;
        ld_base = 64'h3000; ld_imm = 32'd8; ld_size = 2'd3; ld_unsigned = 1'b0; ld_rd = 5'd12;
        ld_valid = 1'b1;
        @(posedge clk);
        #1 ld_valid = 1'b0;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_if.mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("t5_ld_ready", 64'(ld_ready), 64'd1);
        check("t5_wb_wen", 64'(wb_wen), 64'd0);
        check("t5_wdata", wb_wdata, 64'd0);
        check("t5_waddr", 64'(wb_waddr), 64'd0);
        check("t5_req_addr", mem_if.mem_req_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_wdata = '0;
        @(negedge clk);
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk);
        #1 mem_if.mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_stale_wen", 64'(wb_wen), 64'd0);
            check("t5_stale_ready", 64'(ld_ready), 64'd1);
            check("t5_stale_wdata", wb_wdata, 64'd0);
        end

        // 6: misaligned half at 0x1001, then word spilling past the doubleword
        wb_before = wb_seen;
        do_load(64'h1001, 32'd0, 2'd1, 1'b0, 5'd11, 64'h0000_0000_00C3_B200, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("t6_no_wb", 64'(wb_seen - wb_before), 64'd0);
`else
        check("t6_wdata_lit", wb_wdata, 64'hFFFF_FFFF_FFFF_C3B2);
`endif
        do_load(64'h1006, 32'd0, 2'd2, 1'b0, 5'd13, 64'h8899_0000_0000_0000, 0);
        // Aligned load after the misaligned ones still works
        do_load(64'h8000_0000, 32'd4, 2'd2, 1'b0, 5'd14, 64'h8765_4321_0000_0000, 0);

        repeat (2) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
